axi_extend_and_scale: RTL and testbench
=======================================

AXI_EXTEND_AND_SCALE -- requirements
Module: axi_extend_and_scale

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 16: signed input sample width.
REQ-002 SHALL have parameter WIDTH_OUT, default 24: signed output sample width, WIDTH_OUT > WIDTH_IN.
REQ-003 SHALL have parameter SHIFT_W, default 5: width of the shift control.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports i_tdata (input, WIDTH_IN), i_tlast (input, 1), i_tvalid (input, 1) and i_tready (output, 1): AXI-stream input of signed samples.
REQ-007 SHALL have ports o_tdata (output, WIDTH_OUT), o_tlast (output, 1), o_tvalid (output, 1) and o_tready (input, 1): AXI-stream output of signed samples.
REQ-008 SHALL have port shift, input, SHIFT_W: requested left-shift gain.
REQ-009 SHALL have port clear_stats, input, 1: one-cycle pulse that clears the statistics.
REQ-010 SHALL have port sat_flag, output, 1: sticky flag, set when any sample has saturated.
REQ-011 SHALL have port sat_count, output, 16: count of saturated samples.

Function
REQ-012 SHALL compute out = sign_extend(i_tdata) << shift_lat, then saturate to the WIDTH_OUT signed range: max 2^(WIDTH_OUT-1)-1, min -2^(WIDTH_OUT-1).
REQ-013 SHALL clamp shift_lat to WIDTH_OUT-1 when the latched shift exceeds WIDTH_OUT-1.
REQ-014 SHALL latch shift_lat from the shift port on the first beat of each packet.
- First beat means the first accepted beat after reset, or the first accepted beat after a beat with i_tlast=1.
- Shift changes in the middle of a packet SHALL be ignored until the next packet.
REQ-015 SHALL track packet position with a two-state FSM.
- SOP: the next beat is a first beat. Leave SOP on an accepted beat with i_tlast=0.
- MID: inside a packet. Return to SOP on an accepted beat with i_tlast=1.
- A single-beat packet (i_tlast=1 on a first beat) SHALL remain in SOP.
REQ-016 SHALL pipeline the datapath in two registered stages: stage 1 shifts, stage 2 saturates and drives the output.
- Latency SHALL be exactly 2 cycles from input acceptance to o_tvalid while o_tready=1.
REQ-017 SHALL sustain one beat per cycle while o_tready=1.
REQ-018 SHALL implement the pipeline as a stall-able ready chain.
- A stage advances when it is empty or the downstream stage advances.
- i_tready SHALL be 1 whenever stage 1 can advance.
REQ-019 SHALL hold o_tdata, o_tlast and o_tvalid stable while o_tvalid=1 and o_tready=0; no beat is lost or duplicated.
REQ-020 SHALL carry i_tlast alongside its sample to o_tlast unchanged.
REQ-021 SHALL count one saturation event per output beat whose value was clamped.
- The event SHALL be counted when the beat is accepted at the output (o_tvalid & o_tready).
REQ-022 SHALL hold sat_count at 0xFFFF once it reaches 0xFFFF (no wrap).
REQ-023 SHALL set sat_flag on the first saturation event; it stays set until cleared.
REQ-024 SHALL give clear_stats priority: when clear_stats=1 coincides with a saturation event, the next state is sat_count=0 and sat_flag=0 (the event is dropped).
REQ-025 SHALL give an input of exactly the negative full scale that lands on -2^(WIDTH_OUT-1) no saturation event.

Reset
REQ-026 SHALL, while reset_n=0, immediately force the following values:
- o_tvalid=0, o_tlast=0, o_tdata=0
- i_tready=0, both pipeline stages empty
- FSM=SOP, shift_lat=0
- sat_flag=0, sat_count=0
REQ-027 SHALL discard any partially transferred packet when reset_n asserts mid-packet; the first beat after release is treated as a first beat.
REQ-028 SHALL drive i_tready=1 on the first clk edge after reset_n deasserts.

Verification (WIDTH_IN=16, WIDTH_OUT=24)
REQ-029 SHALL cover: shift=4, input 0x7FFF with o_tready=1 -> o_tdata=0x07FFF0 two cycles later; sat_count=0.
REQ-030 SHALL cover: shift=8, inputs 0x7FFF then 0x8000 -> 0x7FFF00 then 0x800000; sat_flag=0.
REQ-031 SHALL cover: shift=9, inputs 0x7FFF then 0x8000 -> 0x7FFFFF then 0x800000; sat_count=2 and sat_flag=1.
- Then pulse clear_stats coincident with a third saturating beat -> sat_count=0 and sat_flag=0.
REQ-032 SHALL cover: 4-beat packet with shift=2 at the first beat and shift changed to 6 at beat 2 -> all 4 beats scaled by 4; the next packet is scaled by 64.
REQ-033 SHALL cover: a 10-beat stream with o_tready held low for 5 cycles mid-stream -> all 10 beats arrive in order with tlast on beat 10, and no duplicates.
REQ-034 SHALL cover: reset_n pulsed low at beat 3 of 6 -> o_tvalid=0 immediately.
- After release, a new packet with shift=1 latches shift=1 on its first beat.
- sat_count=0.

Source files
------------

// File: rtl/axi_extend_and_scale.sv
// axi_extend_and_scale: sign-extends signed AXI-stream samples, left-shifts them by a
// per-packet gain and saturates the result to the output width.
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   i_tdata/i_tlast/i_tvalid/i_tready   input stream (WIDTH_IN signed samples)
//   o_tdata/o_tlast/o_tvalid/o_tready   output stream (WIDTH_OUT signed samples)
//   shift                               requested left shift, sampled on each packet's first beat
//   clear_stats                         one-cycle pulse clearing sat_flag / sat_count
//   sat_flag, sat_count                 sticky saturation flag and saturating event counter
module axi_extend_and_scale #(
    parameter int unsigned WIDTH_IN  = 16,
    parameter int unsigned WIDTH_OUT = 24,
    parameter int unsigned SHIFT_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH_IN-1:0]  i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [WIDTH_OUT-1:0] o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic                 clear_stats,
    output logic                 sat_flag,
    output logic [15:0]          sat_count
);
    // Wide enough to hold any input shifted by up to WIDTH_OUT-1 without overflow.
    localparam int unsigned WideW  = WIDTH_IN + WIDTH_OUT;
    localparam int unsigned AmtW   = $clog2(WIDTH_OUT);
    localparam int unsigned MaxAmt = WIDTH_OUT - 1;

    typedef enum logic {StSop, StMid} state_e;

    state_e                  state_q;
    logic [AmtW-1:0]         shift_lat_q;
    logic                    ready_en_q;

    logic                    s1_valid_q;
    logic                    s1_last_q;
    logic signed [WideW-1:0] s1_data_q;

    logic                    o_tvalid_q;
    logic                    o_tlast_q;
    logic [WIDTH_OUT-1:0]    o_tdata_q;
    logic                    s2_sat_q;

    logic                    sat_flag_q, sat_flag_d;
    logic [15:0]             sat_count_q, sat_count_d;

    logic                    s2_adv, s1_adv, in_fire, out_fire;
    logic [AmtW-1:0]         shift_clamped, amt;
    logic signed [WideW-1:0] in_ext, in_shifted;
    logic                    fits;
    logic [WIDTH_OUT-1:0]    sat_value;

    // Ready chain: a stage advances when empty or when the stage after it advances.
    assign s2_adv   = !o_tvalid_q || o_tready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    // ready_en_q keeps i_tready low during reset and until the first edge after release.
    assign i_tready = ready_en_q && s1_adv;
    assign in_fire  = i_tvalid && i_tready;
    assign out_fire = o_tvalid_q && o_tready;

    always_comb begin
        if (32'(shift) > MaxAmt) begin
            shift_clamped = AmtW'(MaxAmt);
        end else begin
            shift_clamped = AmtW'(shift);
        end
    end

    // The first beat of a packet uses the live shift; later beats use the latched one.
    assign amt        = (state_q == StSop) ? shift_clamped : shift_lat_q;
    assign in_ext     = WideW'($signed(i_tdata));
    assign in_shifted = in_ext <<< amt;

    // Value fits when all bits above the output sign bit replicate it.
    assign fits      = (&s1_data_q[WideW-1:WIDTH_OUT-1]) || !(|s1_data_q[WideW-1:WIDTH_OUT-1]);
    assign sat_value = s1_data_q[WideW-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}}
                                          : {1'b0, {(WIDTH_OUT-1){1'b1}}};

    // Packet-position FSM and per-packet shift latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StSop;
            shift_lat_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (in_fire) begin
                if (state_q == StSop) begin
                    shift_lat_q <= shift_clamped;
                end
                state_q <= i_tlast ? StSop : StMid;
            end
        end
    end

    // Stage 1 shifts, stage 2 saturates and drives the output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            o_tvalid_q <= 1'b0;
            o_tlast_q  <= 1'b0;
            o_tdata_q  <= '0;
            s2_sat_q   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_fire;
                if (in_fire) begin
                    s1_data_q <= in_shifted;
                    s1_last_q <= i_tlast;
                end
            end
            if (s2_adv) begin
                o_tvalid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    o_tdata_q <= fits ? s1_data_q[WIDTH_OUT-1:0] : sat_value;
                    o_tlast_q <= s1_last_q;
                    s2_sat_q  <= !fits;
                end
            end
        end
    end

    // Saturation statistics; a clear wins over a coincident event.
    always_comb begin
        sat_flag_d  = sat_flag_q;
        sat_count_d = sat_count_q;
        if (clear_stats) begin
            sat_flag_d  = 1'b0;
            sat_count_d = '0;
        end else if (out_fire && s2_sat_q) begin
            sat_flag_d = 1'b1;
            if (sat_count_q != 16'hFFFF) begin
                sat_count_d = sat_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            sat_flag_q  <= sat_flag_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign o_tvalid  = o_tvalid_q;
    assign o_tlast   = o_tlast_q;
    assign o_tdata   = o_tdata_q;
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_axi_extend_and_scale.sv
// Bench for axi_extend_and_scale (WIDTH_IN=16, WIDTH_OUT=24): directed scenarios with
// literal expectations, then randomized traffic against an arithmetic reference model.
module tb_axi_extend_and_scale;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [23:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [4:0]  shift = '0;
    logic        clear_stats = 1'b0;
    logic        sat_flag;
    logic [15:0] sat_count;

    axi_extend_and_scale dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_tdata     (i_tdata),
        .i_tlast     (i_tlast),
        .i_tvalid    (i_tvalid),
        .i_tready    (i_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .shift       (shift),
        .clear_stats (clear_stats),
        .sat_flag    (sat_flag),
        .sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model state
    typedef struct packed {logic [23:0] d; logic s;} res_t;
    typedef struct {logic [23:0] d; logic l; logic s; int acc;} exp_t;
    exp_t        q[$];
    logic [23:0] out_log[$];
    logic        out_last_log[$];
    bit          m_sop = 1'b1;
    int          m_shift = 0;
    int          m_cnt = 0;
    bit          m_flag = 1'b0;
    int          last_stall = -100;
    bit          hold_v = 1'b0;
    logic [23:0] hold_d;
    logic        hold_l;
    int          ordy_mode = 0;

    function automatic res_t scale(logic [15:0] x, int s);
        longint v;
        res_t   r;
        v = longint'($signed(x)) * (longint'(1) << s);
        if (v > 64'sd8388607) r = {24'h7FFFFF, 1'b1};
        else if (v < -64'sd8388608) r = {24'h800000, 1'b1};
        else r = {v[23:0], 1'b0};
        return r;
    endfunction

    // Output ready driver: 0 = always ready, 1 = random, 2 = held low.
    always @(posedge clk) begin
        #2;
        case (ordy_mode)
            0: o_tready = 1'b1;
            1: o_tready = ($urandom_range(0, 3) != 0);
            default: o_tready = 1'b0;
        endcase
    end

    // Compare process: sampled on the falling edge, inputs are stable until the next rise.
    always @(negedge clk) begin
        exp_t e;
        res_t r;
        bit   ev;
        cyc++;
        ev = 1'b0;
        if (!reset_n) begin
            check("rst_o_tvalid", o_tvalid, 0);
            check("rst_o_tdata", o_tdata, 0);
            check("rst_i_tready", i_tready, 0);
            check("rst_sat_count", sat_count, 0);
            check("rst_sat_flag", sat_flag, 0);
            q.delete();
            m_sop = 1'b1; m_shift = 0; m_cnt = 0; m_flag = 1'b0; hold_v = 1'b0;
        end else begin
            check("sat_count", sat_count, m_cnt);
            check("sat_flag", sat_flag, m_flag);
            if (hold_v) begin
                check("stall_hold_valid", o_tvalid, 1);
                check("stall_hold_data", o_tdata, hold_d);
                check("stall_hold_last", o_tlast, hold_l);
            end
            if (!o_tready) last_stall = cyc;
            if (o_tvalid && o_tready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", o_tdata, 'x);
                end else begin
                    e = q.pop_front();
                    check("o_tdata", o_tdata, e.d);
                    check("o_tlast", o_tlast, e.l);
                    if (last_stall <= e.acc) check("latency", cyc - e.acc, 2);
                    ev = e.s;
                end
                out_log.push_back(o_tdata);
                out_last_log.push_back(o_tlast);
            end
            hold_v = o_tvalid && !o_tready;
            hold_d = o_tdata;
            hold_l = o_tlast;
            if (clear_stats) begin
                m_cnt = 0; m_flag = 1'b0;
            end else if (ev) begin
                if (m_cnt < 65535) m_cnt++;
                m_flag = 1'b1;
            end
            if (i_tvalid && i_tready) begin
                if (m_sop) m_shift = (shift > 23) ? 23 : int'(shift);
                r = scale(i_tdata, m_shift);
                q.push_back('{d: r.d, l: i_tlast, s: r.s, acc: cyc});
                m_sop = i_tlast;
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic do_reset();
        reset_n = 1'b0; i_tvalid = 1'b0; clear_stats = 1'b0;
        #1 check("reset_immediate_o_tvalid", o_tvalid, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 check("tready_at_release", i_tready, 0);
        @(posedge clk);
        #1 check("tready_after_release", i_tready, 1);
    endtask

    task automatic send(input logic [15:0] d, input logic l, input logic [4:0] s);
        bit got = 1'b0;
        i_tdata = d; i_tlast = l; shift = s; i_tvalid = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk) got = i_tready;
            @(posedge clk);
            #1;
        end
        i_tvalid = 1'b0;
        check("send_accepted", got, 1);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || o_tvalid) && t < 300) begin
            @(posedge clk);
            #1 t++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit got;
        @(posedge clk);
        #1 do_reset();

        // shift=4, 0x7FFF -> 0x07FFF0
        out_log.delete();
        send(16'h7FFF, 1'b1, 5'd4);
        drain();
        check("t1_data", out_log.size() > 0 ? out_log[0] : 24'hx, 24'h07FFF0);
        check("t1_sat_count", sat_count, 0);

        // shift=8: exact full scale both ways, no saturation
        out_log.delete();
        send(16'h7FFF, 1'b0, 5'd8);
        send(16'h8000, 1'b1, 5'd8);
        drain();
        check("t2_pos", out_log.size() > 1 ? out_log[0] : 24'hx, 24'h7FFF00);
        check("t2_neg", out_log.size() > 1 ? out_log[1] : 24'hx, 24'h800000);
        check("t2_flag", sat_flag, 0);

        // shift=9: both saturate
        out_log.delete();
        send(16'h7FFF, 1'b0, 5'd9);
        send(16'h8000, 1'b1, 5'd9);
        drain();
        check("t3_pos", out_log.size() > 1 ? out_log[0] : 24'hx, 24'h7FFFFF);
        check("t3_neg", out_log.size() > 1 ? out_log[1] : 24'hx, 24'h800000);
        check("t3_count", sat_count, 2);
        check("t3_flag", sat_flag, 1);
        // Third saturating beat; clear pulses on the cycle it leaves the output.
        send(16'h4000, 1'b1, 5'd9);
        @(posedge clk);
        #1 check("t3_third_valid", o_tvalid, 1);
        clear_stats = 1'b1;
        @(posedge clk);
        #1 clear_stats = 1'b0;
        check("t3_clr_count", sat_count, 0);
        check("t3_clr_flag", sat_flag, 0);
        drain();

        // Shift latched per packet; mid-packet change ignored
        out_log.delete();
        send(16'h0100, 1'b0, 5'd2);
        send(16'h0123, 1'b0, 5'd6);
        send(16'hFFFF, 1'b0, 5'd6);
        send(16'h1000, 1'b1, 5'd6);
        send(16'h0010, 1'b1, 5'd6);
        drain();
        check("t4_b1", out_log.size() > 4 ? out_log[0] : 24'hx, 24'h000400);
        check("t4_b2", out_log.size() > 4 ? out_log[1] : 24'hx, 24'h00048C);
        check("t4_b3", out_log.size() > 4 ? out_log[2] : 24'hx, 24'hFFFFFC);
        check("t4_b4", out_log.size() > 4 ? out_log[3] : 24'hx, 24'h004000);
        check("t4_next", out_log.size() > 4 ? out_log[4] : 24'hx, 24'h000400);

        // 10-beat stream with a 5-cycle output stall in the middle
        out_log.delete();
        out_last_log.delete();
        fork
            for (int i = 1; i <= 10; i++) send(16'(i), (i == 10), 5'd0);
            begin
                repeat (4) @(posedge clk);
                #1 ordy_mode = 2;
                repeat (5) @(posedge clk);
                #1 ordy_mode = 0;
            end
        join
        drain();
        check("t5_count", out_log.size(), 10);
        for (int i = 0; i < 10 && i < out_log.size(); i++) begin
            check("t5_order", out_log[i], 24'(i + 1));
            check("t5_last", out_last_log[i], (i == 9));
        end

        // Reset in the middle of a packet
        send(16'h0011, 1'b0, 5'd3);
        send(16'h0022, 1'b0, 5'd3);
        check("t6_valid_before_reset", o_tvalid, 1);
        do_reset();
        out_log.delete();
        send(16'h0003, 1'b0, 5'd1);
        send(16'h0005, 1'b1, 5'd7);
        drain();
        check("t6_b1", out_log.size() > 1 ? out_log[0] : 24'hx, 24'h000006);
        check("t6_b2", out_log.size() > 1 ? out_log[1] : 24'hx, 24'h00000A);
        check("t6_count", sat_count, 0);

        // Randomized traffic against the model
        ordy_mode = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk) got = i_tvalid && i_tready;
            @(posedge clk);
            #1;
            clear_stats = ($urandom_range(0, 63) == 0);
            shift = 5'($urandom);
            if (!i_tvalid || got) begin
                i_tvalid = ($urandom_range(0, 3) != 0);
                i_tlast = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0: i_tdata = 16'h7FFF;
                    1: i_tdata = 16'h8000;
                    default: i_tdata = 16'($urandom);
                endcase
            end
        end
        i_tvalid = 1'b0;
        clear_stats = 1'b0;
        ordy_mode = 0;
        @(posedge clk);
        #1 drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
